rvb_arbiter: RTL and testbench

Two-port round-robin arbiter sharing one `rvb_full` bitmanip worker between two requesters, e.g. two PCPI front-ends or two harts. It forwards operands and instruction words to the worker's `din` handshake. A tag FIFO records which requester issued each in-flight operation, so that results on `dout` are routed back to the right requester in issue order. Up to DEPTH operations may be in flight.

---
 rtl/rvb_arbiter_if.sv | 57 +++++
 rtl/rvb_arbiter.sv | 103 ++++++++++
 tb/tb_rvb_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rvb_arbiter_if.sv
// rvb_arbiter_if: bundle of every handshake/bus signal around rvb_arbiter.
//   Requester A/B side : x_req_valid/x_req_ready, x_insn, x_rs1..x_rs3,
//                        x_rsp_valid/x_rsp_ready, x_rsp_rd
//   Worker side        : din_valid/din_ready, din_insn, din_rs1..din_rs3,
//                        dout_valid/dout_ready, dout_rd
//   Debug              : dbg_prio (0 = A preferred), dbg_count (ops in flight)
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clk edge where both valid and ready are high; a valid source holds its
// payload stable until that transfer.
// modport slave is the arbiter's view, modport master is the environment's.
interface rvb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            a_req_valid, a_req_ready;
  logic [31:0]     a_insn;
  logic [XLEN-1:0] a_rs1, a_rs2, a_rs3;
  logic            a_rsp_valid, a_rsp_ready;
  logic [XLEN-1:0] a_rsp_rd;

  logic            b_req_valid, b_req_ready;
  logic [31:0]     b_insn;
  logic [XLEN-1:0] b_rs1, b_rs2, b_rs3;
  logic            b_rsp_valid, b_rsp_ready;
  logic [XLEN-1:0] b_rsp_rd;

  logic            din_valid, din_ready;
  logic [31:0]     din_insn;
  logic [XLEN-1:0] din_rs1, din_rs2, din_rs3;
  logic            dout_valid, dout_ready;
  logic [XLEN-1:0] dout_rd;

  logic            dbg_prio;
  logic [CW-1:0]   dbg_count;

  modport slave (
    input  a_req_valid, a_insn, a_rs1, a_rs2, a_rs3, a_rsp_ready,
    input  b_req_valid, b_insn, b_rs1, b_rs2, b_rs3, b_rsp_ready,
    input  din_ready, dout_valid, dout_rd,
    output a_req_ready, a_rsp_valid, a_rsp_rd,
    output b_req_ready, b_rsp_valid, b_rsp_rd,
    output din_valid, din_insn, din_rs1, din_rs2, din_rs3, dout_ready,
    output dbg_prio, dbg_count
  );

  modport master (
    output a_req_valid, a_insn, a_rs1, a_rs2, a_rs3, a_rsp_ready,
    output b_req_valid, b_insn, b_rs1, b_rs2, b_rs3, b_rsp_ready,
    output din_ready, dout_valid, dout_rd,
    input  a_req_ready, a_rsp_valid, a_rsp_rd,
    input  b_req_ready, b_rsp_valid, b_rsp_rd,
    input  din_valid, din_insn, din_rs1, din_rs2, din_rs3, dout_ready,
    input  dbg_prio, dbg_count
  );
endinterface

// File: rtl/rvb_arbiter.sv
// rvb_arbiter: two-port round-robin arbiter in front of one rvb_full worker.
// Requests are forwarded combinationally to the worker's din port; a tag FIFO
// remembers which requester issued each in-flight op so results on dout are
// steered back to their owner in issue order.
// Ports:
//   clk    - rising-edge clock
//   resetn - asynchronous active-low reset (shared with the worker)
//   bus    - rvb_arbiter_if.slave, all requester/worker handshakes + debug
module rvb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         resetn,
  rvb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic             prio_q, prio_d;      // 0 = A preferred on contention
  logic [DEPTH-1:0] tag_q, tag_d;        // 0 = A owns the op, 1 = B
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic full, empty, sel_a, sel_b, issue, retire, head_b;

  always_comb begin
    full   = (count_q == CW'(DEPTH));
    empty  = (count_q == '0);
    sel_b  = bus.b_req_valid & (~bus.a_req_valid | prio_q);
    sel_a  = bus.a_req_valid & ~sel_b;
    head_b = tag_q[rptr_q];

    // Request path; resetn gating keeps the handshake quiet while in reset.
    bus.din_valid   = resetn & (bus.a_req_valid | bus.b_req_valid) & ~full;
    bus.a_req_ready = resetn & sel_a & bus.din_ready & ~full;
    bus.b_req_ready = resetn & sel_b & bus.din_ready & ~full;
    if (sel_b) begin
      bus.din_insn = bus.b_insn;
      bus.din_rs1  = bus.b_rs1;
      bus.din_rs2  = bus.b_rs2;
      bus.din_rs3  = bus.b_rs3;
    end else if (bus.a_req_valid) begin
      bus.din_insn = bus.a_insn;
      bus.din_rs1  = bus.a_rs1;
      bus.din_rs2  = bus.a_rs2;
      bus.din_rs3  = bus.a_rs3;
    end else begin
      bus.din_insn = '0;
      bus.din_rs1  = '0;
      bus.din_rs2  = '0;
      bus.din_rs3  = '0;
    end
    issue = bus.din_valid & bus.din_ready;

    // Response path; an empty FIFO means dout has no owner, so nothing routes.
    bus.a_rsp_valid = bus.dout_valid & ~empty & ~head_b;
    bus.b_rsp_valid = bus.dout_valid & ~empty & head_b;
    bus.dout_ready  = ~empty & (head_b ? bus.b_rsp_ready : bus.a_rsp_ready);
    bus.a_rsp_rd    = bus.dout_rd;
    bus.b_rsp_rd    = bus.dout_rd;
    retire = bus.dout_valid & bus.dout_ready;

    bus.dbg_prio  = prio_q;
    bus.dbg_count = count_q;

    prio_d  = prio_q;
    tag_d   = tag_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (issue) begin
      tag_d[wptr_q] = sel_b;
      wptr_d        = wptr_q + PW'(1);
      prio_d        = ~sel_b;
    end
    if (retire) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (issue && !retire) begin
      count_d = count_q + CW'(1);
    end else if (retire && !issue) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prio_q  <= 1'b0;
      tag_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      prio_q  <= prio_d;
      tag_q   <= tag_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_rvb_arbiter.sv
// Bench for rvb_arbiter: directed scenarios followed by a random phase, all
// checked every cycle against a queue-based model of the arbitration rules.
module tb_rvb_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  rvb_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  rvb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  bit              inflight[$];          // owner of each in-flight op, 0 = A
  logic [XLEN-1:0] exp_a[$], exp_b[$];    // results each requester must see
  logic [XLEN-1:0] wq[$];                 // echo worker pipeline
  bit              last_b = 1'b1;         // last grant went to B -> A preferred
  bit              dout_en, dout_force;
  bit              acc_a, acc_b;
  int              n_a, n_b;
  bit              grants[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic new_a();
    bus.a_insn = $urandom; bus.a_rs1 = $urandom; bus.a_rs2 = $urandom; bus.a_rs3 = $urandom;
  endtask

  task automatic new_b();
    bus.b_insn = $urandom; bus.b_rs1 = $urandom; bus.b_rs2 = $urandom; bus.b_rs3 = $urandom;
  endtask

  task automatic drive_worker();
    bus.dout_valid = dout_force || (dout_en && wq.size() > 0);
    bus.dout_rd    = (wq.size() > 0) ? wq[0] : '0;
  endtask

  // One clock: check at the falling edge, advance model/worker after the rise.
  task automatic cycle();
    bit ga, gb, full, dv, has_head, head_b, ret, w_push, w_pop;
    logic [XLEN-1:0] a_s, b_s, w_data;
    @(negedge clk);
    full = (inflight.size() == DEPTH);
    gb   = bus.b_req_valid && (!bus.a_req_valid || !last_b);
    ga   = bus.a_req_valid && !gb;
    dv   = (ga || gb) && !full;
    chk("count", bus.dbg_count, inflight.size());
    chk("prio", bus.dbg_prio, !last_b);
    chk("din_valid", bus.din_valid, dv);
    chk("a_req_ready", bus.a_req_ready, ga && bus.din_ready && !full);
    chk("b_req_ready", bus.b_req_ready, gb && bus.din_ready && !full);
    if (ga)
      chk("din_from_a", {bus.din_insn, bus.din_rs1, bus.din_rs2, bus.din_rs3},
          {bus.a_insn, bus.a_rs1, bus.a_rs2, bus.a_rs3});
    else if (gb)
      chk("din_from_b", {bus.din_insn, bus.din_rs1, bus.din_rs2, bus.din_rs3},
          {bus.b_insn, bus.b_rs1, bus.b_rs2, bus.b_rs3});
    else
      chk("din_idle", {bus.din_insn, bus.din_rs1, bus.din_rs2, bus.din_rs3}, 128'd0);
    has_head = inflight.size() > 0;
    head_b   = has_head ? inflight[0] : 1'b0;
    ret      = bus.dout_valid && has_head && (head_b ? bus.b_rsp_ready : bus.a_rsp_ready);
    chk("a_rsp_valid", bus.a_rsp_valid, bus.dout_valid && has_head && !head_b);
    chk("b_rsp_valid", bus.b_rsp_valid, bus.dout_valid && has_head && head_b);
    chk("dout_ready", bus.dout_ready, has_head && (head_b ? bus.b_rsp_ready : bus.a_rsp_ready));
    if (ret && !head_b) chk("a_rsp_rd", bus.a_rsp_rd, exp_a[0]);
    if (ret && head_b)  chk("b_rsp_rd", bus.b_rsp_rd, exp_b[0]);
    acc_a  = ga && bus.din_ready && !full;
    acc_b  = gb && bus.din_ready && !full;
    a_s    = bus.a_rs1;
    b_s    = bus.b_rs1;
    w_push = bus.din_valid && bus.din_ready;
    w_pop  = bus.dout_valid && bus.dout_ready;
    w_data = bus.din_rs1;
    @(posedge clk);
    #1;
    if (ret) begin
      void'(inflight.pop_front());
      if (head_b) void'(exp_b.pop_front());
      else        void'(exp_a.pop_front());
    end
    if (acc_a) begin
      inflight.push_back(1'b0); exp_a.push_back(a_s); last_b = 1'b0;
      grants.push_back(1'b0); n_a++; new_a();
    end
    if (acc_b) begin
      inflight.push_back(1'b1); exp_b.push_back(b_s); last_b = 1'b1;
      grants.push_back(1'b1); n_b++; new_b();
    end
    if (w_pop && wq.size() > 0) void'(wq.pop_front());
    if (w_push) wq.push_back(w_data);
    drive_worker();
  endtask

  task automatic drain();
    bus.a_req_valid = 1'b0; bus.b_req_valid = 1'b0;
    bus.a_rsp_ready = 1'b1; bus.b_rsp_ready = 1'b1;
    bus.din_ready = 1'b1; dout_en = 1'b1; dout_force = 1'b0;
    drive_worker();
    for (int i = 0; i < 40 && inflight.size() > 0; i++) cycle();
    chk("drain_empty", inflight.size(), 0);
  endtask

  task automatic clear_model();
    inflight.delete(); exp_a.delete(); exp_b.delete(); wq.delete();
    last_b = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    resetn = 1'b0;
    bus.a_req_valid = 1'b0; bus.b_req_valid = 1'b0;
    bus.a_rsp_ready = 1'b1; bus.b_rsp_ready = 1'b1;
    bus.din_ready = 1'b1; dout_en = 1'b1; dout_force = 1'b0;
    new_a(); new_b(); drive_worker();
    @(posedge clk); #1;

    // Reset held with both requesting and a spurious dout_valid.
    bus.a_req_valid = 1'b1; bus.b_req_valid = 1'b1;
    dout_force = 1'b1; drive_worker();
    @(negedge clk);
    chk("rst_a_req_ready", bus.a_req_ready, 1'b0);
    chk("rst_b_req_ready", bus.b_req_ready, 1'b0);
    chk("rst_din_valid", bus.din_valid, 1'b0);
    chk("rst_a_rsp_valid", bus.a_rsp_valid, 1'b0);
    chk("rst_b_rsp_valid", bus.b_rsp_valid, 1'b0);
    chk("rst_dout_ready", bus.dout_ready, 1'b0);
    chk("rst_count", bus.dbg_count, 0);
    chk("rst_prio", bus.dbg_prio, 1'b0);
    dout_force = 1'b0; drive_worker();
    @(posedge clk); #1;
    resetn = 1'b1;

    // Contention with a 1-cycle echo worker: grants alternate from A.
    grants.delete();
    repeat (12) cycle();
    chk("contention_n", grants.size(), 12);
    for (int i = 0; i < grants.size(); i++) chk("contention_order", grants[i], i % 2);
    drain();

    // Only B requesting: granted every cycle, no bubble.
    n_b = 0;
    bus.b_req_valid = 1'b1;
    repeat (8) cycle();
    chk("single_b_grants", n_b, 8);
    drain();

    // Fill to DEPTH with results withheld, then retire one while requesting.
    n_a = 0; n_b = 0;
    dout_en = 1'b0; drive_worker();
    bus.a_req_valid = 1'b1; bus.b_req_valid = 1'b1;
    repeat (7) cycle();
    chk("full_issues", n_a + n_b, DEPTH);
    dout_en = 1'b1; drive_worker();
    cycle();
    chk("full_no_issue_on_retire", n_a + n_b, DEPTH);
    dout_en = 1'b0; drive_worker();
    cycle();
    chk("full_resume", n_a + n_b, DEPTH + 1);
    drain();

    // Head blocking: A then B in flight, A not consuming.
    dout_en = 1'b0; drive_worker();
    bus.a_req_valid = 1'b1;
    cycle();
    bus.a_req_valid = 1'b0; bus.b_req_valid = 1'b1;
    cycle();
    bus.b_req_valid = 1'b0;
    bus.a_rsp_ready = 1'b0; dout_en = 1'b1; drive_worker();
    repeat (5) cycle();
    chk("head_block_held", inflight.size(), 2);
    bus.a_rsp_ready = 1'b1;
    cycle();
    chk("head_a_retired", inflight.size(), 1);
    cycle();
    chk("head_b_retired", inflight.size(), 0);

    // Asynchronous reset with 3 ops outstanding.
    dout_en = 1'b0; drive_worker();
    bus.a_req_valid = 1'b1; bus.b_req_valid = 1'b1;
    repeat (3) cycle();
    bus.a_req_valid = 1'b0; bus.b_req_valid = 1'b0;
    chk("pre_reset_outstanding", bus.dbg_count, 3);
    #1 resetn = 1'b0;
    #1;
    chk("async_rst_count", bus.dbg_count, 0);
    chk("async_rst_prio", bus.dbg_prio, 1'b0);
    chk("async_rst_dout_ready", bus.dout_ready, 1'b0);
    clear_model(); drive_worker();
    #1 resetn = 1'b1;
    bus.a_req_valid = 1'b1; dout_en = 1'b1;
    cycle();
    bus.a_req_valid = 1'b0;
    cycle();
    chk("post_reset_routed", inflight.size(), 0);

    // Random phase; a raised request stays raised until accepted.
    acc_a = 1'b0; acc_b = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.a_req_valid || acc_a) bus.a_req_valid = ($urandom_range(0, 2) != 0);
      if (!bus.b_req_valid || acc_b) bus.b_req_valid = ($urandom_range(0, 2) != 0);
      bus.din_ready   = ($urandom_range(0, 3) != 0);
      bus.a_rsp_ready = ($urandom_range(0, 3) != 0);
      bus.b_rsp_ready = ($urandom_range(0, 3) != 0);
      dout_en         = ($urandom_range(0, 2) != 0);
      dout_force      = (inflight.size() == 0) && (wq.size() == 0) && ($urandom_range(0, 7) == 0);
      drive_worker();
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
